vram_arbiter: RTL and testbench

- Shares the single-port 64 KB video RAM between two requesters:
  - the display fetch path, driven by the sync generator's pixel addresses;
  - a CPU-side access port.
- Sits between the VDP scan logic and the RAM instance, and owns the RAM's chip-select, write-enable, address and write data.
- The display has fixed priority. A starvation counter guarantees the CPU a slot.
- Two-stage pipeline: issue, then return. One access is issued per cycle.

---
 rtl/vram_arbiter_pkg.sv | 19 +
 rtl/vram_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared owner-tag encoding and bus-width defaults for the video RAM arbiter.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;
  localparam int WAIT_W      = 8;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_DISP   = 2'd1,
    OWN_CPU_RD = 2'd2,
    OWN_CPU_WR = 2'd3
  } owner_e;

  function automatic logic is_cpu(owner_e own);
    return (own == OWN_CPU_RD) || (own == OWN_CPU_WR);
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads have fixed priority, a starvation
// counter forces a CPU slot; two-stage issue/return pipeline.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  owner_e            grant;
  owner_e            own_s1;
  owner_e            own_s2;
  logic              forced_miss;
  logic              miss_s1;
  logic              miss_s2;
  logic              cpu_busy;
  logic              cpu_pending;
  logic [WAIT_W-1:0] wait_cnt;

  // A CPU request seen while its previous access is still in flight is ignored.
  assign cpu_pending = cpu_req & ~cpu_busy;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    grant       = OWN_NONE;
    forced_miss = 1'b0;
    if (cpu_pending && wait_cnt == LIMIT) begin
      grant       = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
      forced_miss = disp_req;
    end else if (disp_req) begin
      grant = OWN_DISP;
    end else if (cpu_pending) begin
      grant = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset is synchronous; all state, including data registers, is
      // cleared so nothing in flight survives into the post-reset pipeline.
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_wdata_oe <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      own_s1       <= OWN_NONE;
      own_s2       <= OWN_NONE;
      miss_s1      <= 1'b0;
      miss_s2      <= 1'b0;
      disp_valid   <= 1'b0;
      disp_data    <= '0;
      disp_miss    <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      cpu_busy     <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      ram_cs       <= (grant != OWN_NONE);
      ram_we       <= (grant == OWN_CPU_WR);
      ram_wdata_oe <= (grant == OWN_CPU_WR);
      case (grant)
        OWN_DISP:   ram_addr <= disp_addr;
        OWN_CPU_RD: ram_addr <= cpu_addr;
        OWN_CPU_WR: begin
          ram_addr  <= cpu_addr;
          ram_wdata <= cpu_wdata;
        end
        default: ;
      endcase

      own_s1  <= grant;
      miss_s1 <= forced_miss;
      own_s2  <= own_s1;
      miss_s2 <= miss_s1;

      // Return stage: RAM read data is valid while the owner sits in stage 2.
      disp_valid <= (own_s2 == OWN_DISP);
      if (own_s2 == OWN_DISP) disp_data <= ram_rdata;
      cpu_ack <= is_cpu(own_s2);
      if (own_s2 == OWN_CPU_RD) cpu_rdata <= ram_rdata;
      disp_miss <= miss_s2;

      if (is_cpu(grant))       cpu_busy <= 1'b1;
      else if (is_cpu(own_s2)) cpu_busy <= 1'b0;

      if (is_cpu(grant) || !cpu_req) begin
        wait_cnt <= '0;
      end else if (cpu_pending && grant == OWN_DISP && wait_cnt != LIMIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int LIMIT = 8;
  localparam int NRAND = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          disp_miss;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wdata_oe;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_miss(disp_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM: read data appears the cycle after the access.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    disp_req  = 1'b0;
    disp_addr = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          cs;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          dv;
    logic [DW-1:0] ddata;
    logic          miss;
    logic          ack;
    logic [DW-1:0] rdata;
  } vec_t;

  task automatic run_table();
    vec_t vt[$];
    // rst dreq daddr     creq cwe caddr     cwd   | cs we addr     wdata dv ddata             miss ack rdata
    vt.push_back(vec_t'{1, 1, 16'h0100, 1, 1, 16'h1234, 8'h5A, 0, 0, 16'h0000, 8'h00, 0, 8'h00,             0, 0, 8'h00});
    vt.push_back(vec_t'{0, 1, 16'h0100, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0100, 8'h00, 0, 8'h00,             0, 0, 8'h00});
    vt.push_back(vec_t'{0, 1, 16'h0101, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0101, 8'h00, 0, 8'h00,             0, 0, 8'h00});
    vt.push_back(vec_t'{0, 1, 16'h0102, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0102, 8'h00, 1, pat(16'h0100), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 1, 16'h0103, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0103, 8'h00, 1, pat(16'h0101), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 1, 16'h0104, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0104, 8'h00, 1, pat(16'h0102), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 0, 16'h0104, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0104, 8'h00, 1, pat(16'h0103), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 16'h1234, 8'h5A, 1, 1, 16'h1234, 8'h5A, 1, pat(16'h0104), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 16'h1234, 8'h5A, 0, 0, 16'h1234, 8'h5A, 0, pat(16'h0104), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 0, 16'h0000, 1, 1, 16'h1234, 8'h5A, 0, 0, 16'h1234, 8'h5A, 0, pat(16'h0104), 0, 1, 8'h00});
    vt.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 16'h1234, 8'h00, 1, 0, 16'h1234, 8'h5A, 0, pat(16'h0104), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 16'h1234, 8'h00, 0, 0, 16'h1234, 8'h5A, 0, pat(16'h0104), 0, 0, 8'h00});
    vt.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 16'h1234, 8'h00, 0, 0, 16'h1234, 8'h5A, 0, pat(16'h0104), 0, 1, 8'h5A});
    vt.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h1234, 8'h5A, 0, pat(16'h0104), 0, 0, 8'h5A});
    foreach (vt[k]) begin
      reset     = vt[k].rst;
      disp_req  = vt[k].dreq;
      disp_addr = vt[k].daddr;
      cpu_req   = vt[k].creq;
      cpu_we    = vt[k].cwe;
      cpu_addr  = vt[k].caddr;
      cpu_wdata = vt[k].cwd;
      step();
      check($sformatf("vec%0d ram_cs", k),       ram_cs,       vt[k].cs);
      check($sformatf("vec%0d ram_we", k),       ram_we,       vt[k].we);
      check($sformatf("vec%0d ram_wdata_oe", k), ram_wdata_oe, vt[k].cs & vt[k].we);
      check($sformatf("vec%0d ram_addr", k),     ram_addr,     vt[k].addr);
      if (vt[k].we) check($sformatf("vec%0d ram_wdata", k), ram_wdata, vt[k].wdata);
      check($sformatf("vec%0d disp_valid", k),   disp_valid,   vt[k].dv);
      check($sformatf("vec%0d disp_data", k),    disp_data,    vt[k].ddata);
      check($sformatf("vec%0d disp_miss", k),    disp_miss,    vt[k].miss);
      check($sformatf("vec%0d cpu_ack", k),      cpu_ack,      vt[k].ack);
      check($sformatf("vec%0d cpu_rdata", k),    cpu_rdata,    vt[k].rdata);
    end
    reset = 1'b0;
    set_idle();
  endtask

  // ---------------- hand-written corner cases ----------------
  task automatic seq_starve();
    int   cpu_at = -1;
    int   miss_at = -1;
    int   ack_at = -1;
    int   misses = 0;
    logic resumed = 1'b0;
    logic dv10 = 1'b1;
    logic dv11 = 1'b0;
    logic [DW-1:0] dd11 = '0;
    logic [DW-1:0] rd = '0;
    do_reset();
    disp_req = 1'b1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h2000;
    for (int i = 0; i < 16; i++) begin
      disp_addr = 16'h0400 + 16'(i);
      step();
      if (ram_cs && !ram_we && ram_addr == 16'h2000 && cpu_at < 0) cpu_at = i;
      if (disp_miss) begin
        misses++;
        if (miss_at < 0) miss_at = i;
      end
      if (cpu_ack && ack_at < 0) begin
        ack_at  = i;
        rd      = cpu_rdata;
        cpu_req = 1'b0;
      end
      if (i == 9)  resumed = ram_cs && !ram_we && ram_addr == 16'h0409;
      if (i == 10) dv10 = disp_valid;
      if (i == 11) begin
        dv11 = disp_valid;
        dd11 = disp_data;
      end
    end
    check("starve cpu issue cycle", 32'(cpu_at), 32'd8);
    check("starve miss count", 32'(misses), 32'd1);
    check("starve miss cycle", 32'(miss_at), 32'd10);
    check("starve ack cycle", 32'(ack_at), 32'd10);
    check("starve cpu_rdata", rd, pat(16'h2000));
    check("starve display resumes", resumed, 1'b1);
    check("starve no valid in miss slot", dv10, 1'b0);
    check("starve valid after resume", dv11, 1'b1);
    check("starve data after resume", dd11, pat(16'h0409));
    set_idle();
  endtask

  task automatic seq_interleave();
    int cpu_at = -1;
    int ack_at = -1;
    int misses = 0;
    logic [DW-1:0] rd = '0;
    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h2100;
    for (int i = 0; i < 8; i++) begin
      disp_req  = (i % 2 == 0);
      disp_addr = 16'h0500 + 16'(i);
      step();
      if (ram_cs && ram_addr == 16'h2100 && cpu_at < 0) cpu_at = i;
      if (disp_miss) misses++;
      if (cpu_ack && ack_at < 0) begin
        ack_at  = i;
        rd      = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    check("interleave cpu issue cycle", 32'(cpu_at), 32'd1);
    check("interleave miss count", 32'(misses), 32'd0);
    check("interleave ack cycle", 32'(ack_at), 32'd3);
    check("interleave cpu_rdata", rd, pat(16'h2100));
    set_idle();
  endtask

  task automatic seq_held();
    do_reset();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h3000;
    cpu_wdata = 8'h77;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("held[%0d] ram_cs", i), ram_cs, (i % 3 == 0));
      check($sformatf("held[%0d] cpu_ack", i), cpu_ack, (i % 3 == 2));
    end
    set_idle();
  endtask

  task automatic seq_reset_mid();
    int stray = 0;
    do_reset();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h2200;
    step();
    disp_req  = 1'b1;
    disp_addr = 16'h0600;
    step();
    reset = 1'b1;
    step();
    check("rst ram_cs", ram_cs, 1'b0);
    check("rst ram_we", ram_we, 1'b0);
    check("rst ram_wdata_oe", ram_wdata_oe, 1'b0);
    check("rst ram_addr", ram_addr, 16'h0000);
    check("rst cpu_ack", cpu_ack, 1'b0);
    check("rst disp_valid", disp_valid, 1'b0);
    check("rst disp_miss", disp_miss, 1'b0);
    check("rst disp_data", disp_data, 8'h00);
    check("rst cpu_rdata", cpu_rdata, 8'h00);
    reset = 1'b0;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      if (cpu_ack || disp_valid || disp_miss) stray++;
    end
    check("rst no stray pulses", 32'(stray), 32'd0);
    cpu_req  = 1'b1;
    cpu_addr = 16'h2200;
    step();
    check("rst cpu not busy cs", ram_cs, 1'b1);
    check("rst cpu not busy addr", ram_addr, 16'h2200);
    set_idle();
    step();
    step();
  endtask

  // ---------------- randomized traffic vs transaction model ----------------
  typedef struct {
    logic          dv;
    logic [DW-1:0] dd;
    logic          miss;
    logic          ack;
    logic          rd;
    logic [DW-1:0] rd_data;
  } sched_t;

  task automatic new_cpu();
    cpu_req   = 1'b1;
    cpu_we    = 1'($urandom_range(1));
    cpu_addr  = {8'h40, 8'($urandom_range(15))};
    cpu_wdata = 8'($urandom);
  endtask

  task automatic run_random(input int n);
    sched_t        sched[];
    int            cpu_free = 0;
    int            m_wait = 0;
    int            ack_edge = -1;
    logic          pending, forced, g_cpu, g_disp;
    logic          exp_cs, exp_we;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    sched = new[n + 3];
    foreach (sched[k]) sched[k] = '{default: '0};
    do_reset();
    for (int i = 0; i < n; i++) begin
      disp_req  = ($urandom_range(3) != 0);
      disp_addr = ($urandom_range(1) == 0) ? {8'h40, 8'($urandom_range(15))} : 16'($urandom);
      if (!cpu_req && $urandom_range(2) == 0) new_cpu();

      // One access per edge: starved CPU first, then display, then CPU.
      pending = cpu_req && (i >= cpu_free);
      forced  = pending && (m_wait == LIMIT);
      g_cpu   = forced || (pending && !disp_req);
      g_disp  = disp_req && !forced;
      if (!cpu_req || g_cpu)       m_wait = 0;
      else if (pending && g_disp)  m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      exp_cs = g_cpu || g_disp;
      exp_we = g_cpu && cpu_we;
      if (g_cpu) begin
        last_addr          = cpu_addr;
        sched[i + 2].ack   = 1'b1;
        sched[i + 2].rd    = !cpu_we;
        sched[i + 2].miss  = forced && disp_req;
        if (cpu_we) begin
          ref_mem[cpu_addr] = cpu_wdata;
          exp_wdata         = cpu_wdata;
        end else begin
          sched[i + 2].rd_data = ref_mem[cpu_addr];
        end
        cpu_free = i + 3;
        ack_edge = i + 2;
      end else if (g_disp) begin
        last_addr        = disp_addr;
        sched[i + 2].dv  = 1'b1;
        sched[i + 2].dd  = ref_mem[disp_addr];
      end

      step();
      check($sformatf("rand[%0d] ram_cs", i), ram_cs, exp_cs);
      check($sformatf("rand[%0d] ram_we", i), ram_we, exp_we);
      check($sformatf("rand[%0d] ram_wdata_oe", i), ram_wdata_oe, exp_we);
      check($sformatf("rand[%0d] ram_addr", i), ram_addr, last_addr);
      if (exp_we) check($sformatf("rand[%0d] ram_wdata", i), ram_wdata, exp_wdata);
      check($sformatf("rand[%0d] disp_valid", i), disp_valid, sched[i].dv);
      if (sched[i].dv) check($sformatf("rand[%0d] disp_data", i), disp_data, sched[i].dd);
      check($sformatf("rand[%0d] disp_miss", i), disp_miss, sched[i].miss);
      check($sformatf("rand[%0d] cpu_ack", i), cpu_ack, sched[i].ack);
      if (sched[i].ack && sched[i].rd)
        check($sformatf("rand[%0d] cpu_rdata", i), cpu_rdata, sched[i].rd_data);

      if (i == ack_edge) begin
        if ($urandom_range(1) == 0) new_cpu();
        else                        cpu_req = 1'b0;
      end
    end
    set_idle();
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = pat(16'(a));
      ref_mem[a] = pat(16'(a));
    end
    // Writes performed by the directed tests before the random phase.
    ref_mem[16'h1234] = 8'h5A;
    ref_mem[16'h3000] = 8'h77;

    run_table();
    seq_starve();
    seq_interleave();
    seq_held();
    seq_reset_mid();
    run_random(NRAND);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
